// File: rtl/eth_txsched.sv
// Four-source packet round-robin scheduler into the shared Ethernet TX FIFO.
// Optional per-source packet counters: define ETH_TXSCHED_STATS_EN.
module eth_txsched #(
  parameter int unsigned MAX_BEATS = 256,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0][73:0]      src_dout,
  input  logic [3:0]            src_empty,
  output logic [3:0]            src_rd_en,
  output logic [75:0]           din,
  input  logic                  full,
  output logic                  wr_en,
  output logic [3:0]            err_trunc,
  input  logic                  err_clr,
  output logic [3:0][CNT_W-1:0] pkt_cnt
);

  localparam int unsigned BW = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t        state;
  logic [1:0]    grant;
  logic [1:0]    last_grant;
  logic [1:0]    next_grant;
  logic [BW-1:0] beat_cnt;
  logic [73:0]   head;
  logic          tlast;
  logic          pop;
  logic          pkt_done;
  logic          at_limit;
  logic          any_req;

  // Pop decode and round-robin pick starting just after the last winner
  always_comb begin
    head      = src_dout[grant];
    tlast     = head[1];
    pop       = ((state == XFER) && !src_empty[grant] && !full) ||
                ((state == DROP) && !src_empty[grant]);
    src_rd_en = '0;
    if (pop) src_rd_en[grant] = 1'b1;
    pkt_done  = pop && tlast;
    at_limit  = (beat_cnt + BW'(1)) == BW'(MAX_BEATS);
    any_req   = ~&src_empty;
    next_grant = last_grant;
    for (int k = 4; k >= 1; k--) begin
      if (!src_empty[last_grant + 2'(k)]) next_grant = last_grant + 2'(k);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 2'd0;
      last_grant <= 2'd3;
      beat_cnt   <= '0;
      wr_en      <= 1'b0;
      din        <= '0;
      err_trunc  <= '0;
    end else begin
      wr_en <= 1'b0;
      // A truncation set below overrides this clear for its own bit
      if (err_clr) err_trunc <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant    <= next_grant;
            beat_cnt <= '0;
            state    <= XFER;
          end
        end
        XFER: begin
          if (pop) begin
            wr_en    <= 1'b1;
            din      <= {grant, head};
            beat_cnt <= beat_cnt + BW'(1);
            if (tlast) begin
              last_grant <= grant;
              state      <= IDLE;
            end else if (at_limit) begin
              din              <= {grant, head[73:2], 1'b1, head[0]};
              err_trunc[grant] <= 1'b1;
              state            <= DROP;
            end
          end
        end
        DROP: begin
          if (pkt_done) begin
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ETH_TXSCHED_STATS_EN
  // Counts completed packets, truncated ones included, at their tlast pop
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt <= '0;
    end else if (pkt_done) begin
      pkt_cnt[grant] <= pkt_cnt[grant] + CNT_W'(1);
    end
  end
`else
  assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_eth_txsched.sv
// Self-checking bench for eth_txsched: FIFO-backed sources, packet-level reference model.
module tb_eth_txsched;

  localparam int unsigned MB = 4;
  localparam int unsigned CW = 16;

  logic               clk;
  logic               rst;
  logic [3:0][73:0]   src_dout;
  logic [3:0]         src_empty;
  logic [3:0]         src_rd_en;
  logic [75:0]        din;
  logic               full;
  logic               wr_en;
  logic [3:0]         err_trunc;
  logic               err_clr;
  logic [3:0][CW-1:0] pkt_cnt;

  eth_txsched #(.MAX_BEATS(MB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .src_dout(src_dout), .src_empty(src_empty),
    .src_rd_en(src_rd_en), .din(din), .full(full), .wr_en(wr_en),
    .err_trunc(err_trunc), .err_clr(err_clr), .pkt_cnt(pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [73:0] srcq [4][$];
  logic [75:0] expq [$];
  int          wcyc [$];
  int          ncmp;
  int          nfail;
  int          mlg;
  logic [3:0]  exp_err;
  int          exp_pkt [4];
  logic [3:0]  obs_rd;
  logic        obs_wr;
  logic [75:0] obs_din;
  int          n_pops, n_wrs, first_pop, first_wr, stall_pops, stall_wrs;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    ncmp++;
    assert (got === want) else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // One clock: present FIFO heads, sample outputs, then pop what the DUT consumed
  task automatic cyc_step();
    for (int i = 0; i < 4; i++) begin
      src_empty[i] = (srcq[i].size() == 0);
      src_dout[i]  = (srcq[i].size() == 0) ? 74'd0 : srcq[i][0];
    end
    #1;
    obs_rd  = src_rd_en;
    obs_wr  = wr_en;
    obs_din = din;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (obs_rd[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
  endtask

  task automatic add_pkt(input int src, input int len, input int tl);
    for (int j = 1; j <= len; j++) begin
      logic [95:0] r;
      logic [73:0] b;
      r    = {$urandom, $urandom, $urandom};
      b    = r[73:0];
      b[1] = (j == tl);
      srcq[src].push_back(b);
    end
  endtask

  // Packet-level reference: round-robin over whole packets, truncation at MB beats
  task automatic model_build();
    logic [73:0] pk [4][$];
    for (int i = 0; i < 4; i++) pk[i] = srcq[i];
    while (1) begin
      int sel;
      int n;
      bit done;
      bit trunc;
      sel = -1;
      for (int k = 1; k <= 4; k++) begin
        int j;
        j = (mlg + k) % 4;
        if (sel < 0 && pk[j].size() > 0) sel = j;
      end
      if (sel < 0) break;
      n = 0; done = 0; trunc = 0;
      while (!done && pk[sel].size() > 0) begin
        logic [73:0] b;
        b = pk[sel].pop_front();
        n++;
        done = b[1];
        if (!trunc) begin
          if (!done && n == int'(MB)) begin
            b[1]  = 1'b1;
            trunc = 1;
          end
          expq.push_back({2'(sel), b});
        end
      end
      exp_pkt[sel]++;
      if (trunc) exp_err[sel] = 1'b1;
      mlg = sel;
    end
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_err"}, 128'(err_trunc), 128'(exp_err));
    for (int i = 0; i < 4; i++) begin
`ifdef ETH_TXSCHED_STATS_EN
      chk({tag, "_pkt_cnt"}, 128'(pkt_cnt[i]), 128'(CW'(exp_pkt[i])));
`else
      chk({tag, "_pkt_cnt"}, 128'(pkt_cnt[i]), 128'(0));
`endif
    end
  endtask

  task automatic run_check(input string tag, input int fs, input int fe, input bit rnd);
    int c;
    int idle;
    model_build();
    n_pops = 0; n_wrs = 0; first_pop = -1; first_wr = -1; stall_pops = 0; stall_wrs = 0;
    wcyc.delete();
    c = 0; idle = 0;
    while (c < 400) begin
      full = rnd ? ($urandom_range(0, 3) == 0) : (c >= fs && c < fe);
      cyc_step();
      chk({tag, "_rd_onehot0"}, 128'($onehot0(obs_rd)), 128'(1));
      if (obs_rd != 4'd0) begin
        n_pops++;
        if (first_pop < 0) first_pop = c;
        if (c >= fs && c < fe) stall_pops++;
      end
      if (obs_wr) begin
        logic [75:0] e;
        e = 'x;
        if (expq.size() > 0) e = expq.pop_front();
        chk({tag, "_din"}, 128'(obs_din), 128'(e));
        n_wrs++;
        wcyc.push_back(c);
        if (first_wr < 0) first_wr = c;
        if (c > fs && c <= fe) stall_wrs++;
      end
      if (srcq[0].size() + srcq[1].size() + srcq[2].size() + srcq[3].size() == 0 &&
          !obs_wr && obs_rd == 4'd0) idle++;
      else idle = 0;
      if (idle >= 3) break;
      c++;
    end
    full = 1'b0;
    chk({tag, "_timeout"}, 128'(c < 400), 128'(1));
    chk({tag, "_missing_wr"}, 128'(expq.size()), 128'(0));
    expq.delete();
    check_status(tag);
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    cyc_step();
    err_clr = 1'b0;
    exp_err = '0;
    chk("err_clr", 128'(err_trunc), 128'(0));
  endtask

  initial begin
    int bad;
    ncmp = 0; nfail = 0; mlg = 3; exp_err = '0;
    for (int i = 0; i < 4; i++) exp_pkt[i] = 0;
    rst = 1'b1; full = 1'b0; err_clr = 1'b0; src_dout = '0; src_empty = 4'hf;
    @(posedge clk); #1;
    cyc_step();
    cyc_step();
    chk("rst_wr_en", 128'(wr_en), 128'(0));
    chk("rst_din", 128'(din), 128'(0));
    chk("rst_rd_en", 128'(src_rd_en), 128'(0));
    check_status("rst");
    rst = 1'b0;

    // Single 3-beat packet on source 2
    add_pkt(2, 3, 3);
    run_check("t1", -1, -1, 0);
    chk("t1_first_pop", 128'(first_pop), 128'(1));
    chk("t1_pops", 128'(n_pops), 128'(3));
    chk("t1_first_wr", 128'(first_wr), 128'(2));
    chk("t1_wrs", 128'(n_wrs), 128'(3));

    // Two 2-beat packets on every source: strict rotation with one idle cycle
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < 4; s++) add_pkt(s, 2, 2);
    run_check("t2", -1, -1, 0);
    chk("t2_wrs", 128'(wcyc.size()), 128'(16));
    bad = 0;
    if (wcyc.size() == 16) begin
      for (int k = 0; k < 8; k++) if (wcyc[2*k+1] - wcyc[2*k] != 1) bad++;
      for (int k = 0; k < 7; k++) if (wcyc[2*k+2] - wcyc[2*k+1] != 2) bad++;
    end
    chk("t2_gaps", 128'(bad), 128'(0));

    // full held for 5 cycles across beat 2 of a 4-beat packet on source 0
    add_pkt(0, 4, 4);
    add_pkt(1, 2, 2);
    run_check("t3", 2, 7, 0);
    chk("t3_stall_pops", 128'(stall_pops), 128'(0));
    chk("t3_stall_wrs", 128'(stall_wrs), 128'(0));
    chk("t3_wrs", 128'(n_wrs), 128'(6));

    // 6-beat packet on source 1 truncated at MB
    add_pkt(1, 6, 6);
    run_check("t4", -1, -1, 0);
    chk("t4_pops", 128'(n_pops), 128'(6));
    chk("t4_wrs", 128'(n_wrs), 128'(4));
    chk("t4_err", 128'(err_trunc), 128'(4'b0010));
    clear_err();

    // Exactly MB beats completes normally
    add_pkt(3, 4, 4);
    run_check("t5", -1, -1, 0);
    chk("t5_wrs", 128'(n_wrs), 128'(4));
    chk("t5_err", 128'(err_trunc), 128'(0));

    // Randomised packet mixes with random backpressure
    for (int r = 0; r < 4; r++) begin
      for (int s = 0; s < 4; s++) begin
        int np;
        np = $urandom_range(0, 2);
        for (int p = 0; p < np; p++) begin
          int len;
          len = $urandom_range(1, 6);
          add_pkt(s, len, len);
        end
      end
      run_check("rnd", -1, -1, 1);
      clear_err();
    end

    // Reset on beat 2 of a packet, then source 0 wins first
    add_pkt(3, 4, 4);
    cyc_step();
    cyc_step();
    chk("rst2_beat1", 128'(obs_rd), 128'(4'b1000));
    rst = 1'b1;
    cyc_step();
    for (int i = 0; i < 4; i++) srcq[i].delete();
    add_pkt(3, 2, 2);
    add_pkt(0, 2, 2);
    rst = 1'b0;
    cyc_step();
    chk("rst2_rd_en", 128'(obs_rd), 128'(0));
    chk("rst2_wr_en", 128'(obs_wr), 128'(0));
    mlg = 3; exp_err = '0;
    for (int i = 0; i < 4; i++) exp_pkt[i] = 0;
    run_check("rst2", -1, -1, 0);
    chk("rst2_wrs", 128'(n_wrs), 128'(4));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/eth_txsched.md
Name: eth_txsched

Overview:
- Four-source, packet-granular round-robin scheduler feeding the shared Ethernet TX FIFO.
- Sources are the CQ, CC, RQ and RC packet FIFOs, indexed 0..3 in that order.
- Each forwarded beat is tagged with a 2-bit source ID and written as a 76-bit entry.
- A per-packet beat watchdog truncates runaway packets so a broken source cannot stall the link.

Parameters:
- MAX_BEATS, 256: maximum beats per packet before forced truncation; legal range 2..1023.
- CNT_W, 16: width of the per-source packet counters (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- src_dout  in  4x74  source FIFO heads (FWFT); bit 1 = tlast, other bits opaque
- src_empty  in  4  source FIFO empty flags
- src_rd_en  out  4  source pop strobes, one-hot or zero
- din  out  76  {src_id[1:0], entry[73:0]} written to the TX FIFO
- full  in  1  TX FIFO almost-full; guarantees at least 2 free entries when low
- wr_en  out  1  TX FIFO write strobe
- err_trunc  out  4  sticky per-source truncation flags
- err_clr  in  1  clears err_trunc
- pkt_cnt  out  4xCNT_W  packets forwarded per source (optional feature)

Behaviour:
- Reset values:
  - state = IDLE, last_grant = 3, so source 0 wins first.
  - src_rd_en = 0, wr_en = 0, din = 0, err_trunc = 0, pkt_cnt = 0, beat_cnt = 0.
- Pop rule:
  - src_rd_en is combinational: src_rd_en[g] = (state==XFER && !src_empty[g] && !full) || (state==DROP && !src_empty[g]).
  - A beat is consumed in every cycle where src_rd_en[g] is high.
- Write path:
  - Registered, latency 1.
  - A beat consumed in XFER at cycle N gives wr_en=1 at N+1, with din = {g, src_dout[g]} sampled at N.
  - No write in any other cycle.
- IDLE:
  - If any src_empty bit is low, grant g = first non-empty index scanning last_grant+1, +2, +3, +4 (mod 4).
  - On grant: beat_cnt <= 0, go to XFER. No pop occurs in IDLE.
  - Consequence: a minimum 1-cycle gap between packets.
- XFER, on each consumed beat:
  - beat_cnt increments.
  - If tlast=1: last_grant <= g, pkt_cnt[g]++ (wraps at 2^CNT_W), go to IDLE.
  - Else if beat_cnt+1 == MAX_BEATS: write the beat with entry bit 1 forced to 1, set err_trunc[g], go to DROP.
  - Else if neither: stay in XFER.
  - Source empty or full high: stall, no pop, no timeout progress.
- DROP:
  - Pop and discard source g (no writes, full ignored) until a beat with tlast=1 is consumed.
  - Then last_grant <= g and go to IDLE. pkt_cnt[g] increments once for the truncated packet.
- err_trunc:
  - err_clr=1 clears all bits.
  - A set event in the same cycle wins over the clear.
- Boundary conditions:
  - Packet of exactly MAX_BEATS beats, last beat tlast=1: normal completion, no error.
  - Single-beat packet (tlast on first beat): 1 pop, 1 write, back to IDLE.
  - full asserting mid-packet stalls between beats; the packet is never interleaved with another source.
  - rst mid-packet: immediate return to reset values. The partially written packet is not repaired; the downstream FIFO is reset together with this block.
- Illegal state encodings return to IDLE.

Optional Feature:
- Macro: ETH_TXSCHED_STATS_EN.
- Defined: pkt_cnt counters are implemented as described above.
- Undefined: pkt_cnt is tied to 0 and no counter flops are inferred. All other behaviour is identical.

Test Plan:
- Reset, then one 3-beat packet on source 2 (tlast on beat 3): src_rd_en[2] high for 3 cycles starting 1 cycle after grant; wr_en high 3 cycles, 1 cycle later; din[75:74]=2; pkt_cnt[2]=1.
- All four sources hold two 2-beat packets each: packet order 0,1,2,3,0,1,2,3, with exactly 1 idle cycle between packets.
- full held high for 5 cycles during beat 2 of a 4-beat packet: no pops or writes during the stall; resumes with beat 2; no other source is interleaved.
- MAX_BEATS=4, source 1 sends 6 beats with tlast on beat 6: 4 writes, the 4th has bit 1 = 1; beats 5-6 are popped but not written; err_trunc = 4'b0010; err_clr clears it.
- Exactly-MAX_BEATS packet (4 beats, tlast on beat 4): 4 writes, err_trunc stays 0.
- rst asserted on beat 2 of a packet: next cycle src_rd_en=0, wr_en=0; after release, source 0 is granted first.
